// File: rtl/kv_pkg.sv
// -----------------------------------------------------------------------------
// kv_pkg
// Shared types for the key/value store controller.
//   kv_op_e    : request opcode carried on the request port
//   kv_state_e : controller FSM states
// -----------------------------------------------------------------------------
package kv_pkg;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_WRITE  = 2'b01,
        OP_DELETE = 2'b10,
        OP_CLEAR  = 2'b11
    } kv_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } kv_state_e;

endpackage

// File: rtl/kv_store_mem.sv
// -----------------------------------------------------------------------------
// kv_store_mem
// Data array of the key/value store: 2**ADDR_W words of DATA_W bits.
// Synchronous write, registered read, and no reset on the storage.
// Ports:
//   clk        : clock, rising edge
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_addr  : read address, captured on every rising edge
//   o_rd_data  : registered read data (word at i_rd_addr from the previous edge)
// -----------------------------------------------------------------------------
module kv_store_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;

    // The controller issues at most one request per edge, so a read never
    // targets a word being written on the same edge; a write is visible to a
    // read issued on the following edge.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/kv_store_ctrl.sv
// -----------------------------------------------------------------------------
// kv_store_ctrl
// Key/value store controller with a valid bit per key, hit/miss reporting,
// delete, and a one-entry-per-cycle clear-all sweep.
// Ports:
//   clk          : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   i_req_valid  : request present
//   o_req_ready  : request can be accepted (low while a clear sweep runs)
//   i_req_op     : 00 READ, 01 WRITE, 10 DELETE, 11 CLEAR
//   i_req_key    : entry index (ignored for CLEAR)
//   i_req_data   : write data (WRITE only)
//   o_rsp_valid  : one-cycle response pulse
//   o_rsp_data   : READ hit data, otherwise 0
//   o_rsp_hit    : key was valid before the operation (CLEAR reports 1)
//   o_count      : number of valid entries, 0..DEPTH
//   o_busy       : clear sweep in progress
// -----------------------------------------------------------------------------
module kv_store_ctrl
    import kv_pkg::*;
#(
    parameter int KEY_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        i_req_op,
    input  logic [KEY_W-1:0]  i_req_key,
    input  logic [DATA_W-1:0] i_req_data,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_hit,
    output logic [KEY_W:0]    o_count,
    output logic              o_busy
);

    localparam int DEPTH = 1 << KEY_W;

    kv_state_e         r_state;
    kv_state_e         w_next_state;
    logic [DEPTH-1:0]  r_valid;
    logic [KEY_W:0]    r_count;
    logic [KEY_W-1:0]  r_idx;
    logic              r_rsp_valid;
    logic              r_rsp_hit;
    logic              r_rsp_rd_hit;
    logic              w_accept;
    logic              w_prior_valid;
    logic              w_sweep_last;
    logic              w_mem_wr_en;
    logic [DATA_W-1:0] w_mem_rd_data;
    kv_op_e            w_op;

    assign w_op          = kv_op_e'(i_req_op);
    assign w_accept      = i_req_valid && o_req_ready;
    assign w_prior_valid = r_valid[i_req_key];
    assign w_sweep_last  = (r_idx == KEY_W'(DEPTH - 1));
    assign w_mem_wr_en   = w_accept && (w_op == OP_WRITE);

    kv_store_mem #(
        .ADDR_W (KEY_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_mem_wr_en),
        .i_wr_addr (i_req_key),
        .i_wr_data (i_req_data),
        .i_rd_addr (i_req_key),
        .o_rd_data (w_mem_rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_req_ready  = 1'b0;
        o_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (w_accept && (w_op == OP_CLEAR)) begin
                    w_next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                o_busy = 1'b1;
                if (w_sweep_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Valid bits, entry count, sweep index and the registered response.
    // r_rsp_rd_hit marks a READ hit so the registered memory word is passed
    // through on the response cycle; every other response returns zero data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= '0;
            r_count      <= '0;
            r_idx        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_hit    <= 1'b0;
            r_rsp_rd_hit <= 1'b0;
        end else begin
            r_rsp_valid  <= 1'b0;
            r_rsp_hit    <= 1'b0;
            r_rsp_rd_hit <= 1'b0;
            if (r_state == ST_CLEAR) begin
                r_valid[r_idx] <= 1'b0;
                if (r_valid[r_idx]) begin
                    r_count <= r_count - (KEY_W+1)'(1);
                end
                r_idx <= r_idx + KEY_W'(1);
                if (w_sweep_last) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_hit   <= 1'b1;
                end
            end else if (w_accept) begin
                case (w_op)
                    OP_READ: begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_hit    <= w_prior_valid;
                        r_rsp_rd_hit <= w_prior_valid;
                    end
                    OP_WRITE: begin
                        r_valid[i_req_key] <= 1'b1;
                        if (!w_prior_valid) begin
                            r_count <= r_count + (KEY_W+1)'(1);
                        end
                        r_rsp_valid <= 1'b1;
                        r_rsp_hit   <= w_prior_valid;
                    end
                    OP_DELETE: begin
                        r_valid[i_req_key] <= 1'b0;
                        if (w_prior_valid) begin
                            r_count <= r_count - (KEY_W+1)'(1);
                        end
                        r_rsp_valid <= 1'b1;
                        r_rsp_hit   <= w_prior_valid;
                    end
                    OP_CLEAR: begin
                        r_idx <= '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_hit   = r_rsp_hit;
    assign o_rsp_data  = r_rsp_rd_hit ? w_mem_rd_data : '0;
    assign o_count     = r_count;

endmodule

// File: doc/kv_store_ctrl.md
# kv_store_ctrl

Parametrised key/value store controller with per-entry valid tracking, hit/miss reporting, delete and a sequenced clear-all operation. It replaces the earlier fixed 16x32 indexed store: storage data is no longer reset, and presence is tracked with a valid bit per key. It sits behind a single-request/registered-response port and is used by control logic as a small lookup table.

## Interface
- KEY_W, 4, key width; DEPTH = 2**KEY_W entries
- DATA_W, 32, data width
- clk  input  1  clock, rising edge
- reset_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request (0 while clearing)
- req_op  input  2  00 READ, 01 WRITE, 10 DELETE, 11 CLEAR
- req_key  input  KEY_W  entry index (ignored for CLEAR)
- req_data  input  DATA_W  write data (WRITE only)
- rsp_valid  output  1  one-cycle response pulse
- rsp_data  output  DATA_W  READ hit data, else 0
- rsp_hit  output  1  key was valid before the op (CLEAR: always 1)
- count  output  KEY_W+1  number of valid entries, 0..DEPTH
- busy  output  1  CLEAR sweep in progress

## Operation
- Request accepted on a rising edge with req_valid && req_ready. No response backpressure: the consumer must always take rsp_valid.
- FSM states: IDLE, CLEAR.
  - IDLE: req_ready=1, busy=0. READ, WRITE and DELETE complete in IDLE. CLEAR moves to CLEAR with sweep index 0.
  - CLEAR: req_ready=0, busy=1. One entry cleared per cycle (valid[idx]<=0, idx++). After idx DEPTH-1, return to IDLE.
- READ:
  - rsp_hit=valid[key]; rsp_data=data[key] if hit, else 0.
  - No state change.
- WRITE:
  - data[key]<=req_data; valid[key]<=1; rsp_hit=prior valid.
  - count+1 only if the key was previously invalid; overwrite leaves count unchanged.
- DELETE:
  - valid[key]<=0; rsp_hit=prior valid; count-1 only if the key was valid.
  - Data is not modified.
- CLEAR:
  - count decrements by 1 for each valid entry swept, so count=0 at completion.
  - rsp_hit=1, rsp_data=0.
- count never wraps: max DEPTH, min 0, guaranteed by the rules above.
- Reset (asynchronous, any state, including mid-CLEAR) drives:
  - FSM to IDLE, all valid bits to 0, count=0
  - rsp_valid=0, rsp_data=0, rsp_hit=0, busy=0, sweep index 0
  - Data array is not reset.
- After reset, req_ready=1.

## Timing
- READ, WRITE, DELETE accepted at edge T: response registered, rsp_valid=1 for the cycle after T (one-cycle latency).
- Back-to-back requests are allowed every cycle in IDLE.
  - A READ accepted at T+1 of a key written at T returns the new data with hit=1.
  - A READ at T+1 of a key deleted at T returns hit=0.
- CLEAR accepted at edge T:
  - busy=1 and req_ready=0 for the next DEPTH cycles.
  - rsp_valid=1 in the cycle after the last sweep cycle, i.e. DEPTH+1 cycles after T.
  - req_ready is 1 in that same cycle.
- req_valid with req_ready=0 is not accepted and produces no response; the requester must hold it.

## Structure
- Package kv_pkg holds:
  - enum kv_op_e: OP_READ=2'b00, OP_WRITE=2'b01, OP_DELETE=2'b10, OP_CLEAR=2'b11
  - enum kv_state_e: ST_IDLE, ST_CLEAR
- Sub-module kv_store_mem: DEPTH x DATA_W data array, synchronous write, registered read, no reset.
- The valid vector, count and FSM stay in kv_store_ctrl.

## Test plan
- Reset, then READ key 3 -> rsp_valid next cycle, rsp_hit=0, rsp_data=0, count=0.
- WRITE key 5 = 0xDEADBEEF, READ key 5 on the next cycle -> first response hit=0 with count=1; second response hit=1, data 0xDEADBEEF.
- WRITE key 5 again = 0x1 -> hit=1, count stays 1. DELETE key 5 twice -> hit=1 with count=0, then hit=0 with count=0.
- Fill all 16 keys (KEY_W=4), then CLEAR:
  - busy high for 16 cycles, req_ready low throughout, count decrementing to 0
  - rsp_valid at T+17, rsp_hit=1
  - a request held during busy is accepted only after completion
- Assert reset_n mid-CLEAR (after 7 sweep cycles) -> immediately busy=0, count=0, all keys miss on READ, req_ready=1 after reset release.
